// File: rtl/mem_access_unit.sv
// Load/store initiator for the big-endian data RAM: accepts one CPU request at a
// time, rejects illegal accesses before they reach the RAM, and returns extended load data.
module mem_access_unit #(
    parameter int RAM_BYTES   = 4096,
    parameter int CHECK_ALIGN = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic [1:0]  mem_storeops,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        store_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        accept;
    logic        req_fault;
    logic [31:0] load_data;

    // Illegal size, misalignment, or any byte beyond the end of the RAM. The end
    // address is computed in 33 bits so addresses near 2^32 cannot wrap into range.
    function automatic logic access_fault(input logic [31:0] addr, input logic [1:0] size);
        logic [32:0] nbytes;
        logic [32:0] end_addr;
        logic        bad;
        nbytes   = 33'd1 << size;
        end_addr = {1'b0, addr} + nbytes;
        bad      = (size == 2'd3) || (end_addr > 33'(RAM_BYTES));
        if (CHECK_ALIGN != 0) begin
            if (size == 2'd1 && addr[0])
                bad = 1'b1;
            if (size == 2'd2 && addr[1:0] != 2'b00)
                bad = 1'b1;
        end
        return bad;
    endfunction

    // The addressed byte is always the most significant lane of the read word.
    function automatic logic [31:0] extend_load(input logic [31:0] rd, input logic [1:0] size,
                                                input logic uns);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] word_s;
        logic [31:0]        result;
        byte_s = rd[31:24];
        half_s = rd[31:16];
        word_s = '0;
        case (size)
            2'd0: begin
                word_s = byte_s;
                result = uns ? {24'd0, rd[31:24]} : word_s;
            end
            2'd1: begin
                word_s = half_s;
                result = uns ? {16'd0, rd[31:16]} : word_s;
            end
            default: result = rd;
        endcase
        return result;
    endfunction

    assign accept    = req_valid && (state == IDLE);
    assign req_fault = access_fault(req_addr, req_size);
    assign load_data = extend_load(mem_read_data, size_q, uns_q);

    always_ff @(posedge CLK) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_memwrite = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = req_fault ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_memwrite = store_q;
                state_nxt    = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture at acceptance, response capture during the single RAM cycle
    always_ff @(posedge CLK) begin
        if (reset) begin
            store_q        <= 1'b0;
            size_q         <= 2'd0;
            uns_q          <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_storeops   <= 2'd0;
            resp_rdata     <= '0;
            resp_fault     <= 1'b0;
        end else begin
            if (accept) begin
                store_q        <= req_store;
                size_q         <= req_size;
                uns_q          <= req_unsigned;
                mem_addr       <= req_addr;
                mem_write_data <= req_wdata;
                mem_storeops   <= req_size;
                resp_rdata     <= '0;
                resp_fault     <= req_fault;
            end
            if (state == ACCESS) begin
                resp_rdata <= store_q ? 32'd0 : load_data;
                resp_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: big-endian RAM behind the port, plus a byte-array
// reference model of memory contents and fault rules used for every expectation.
module tb_mem_access_unit;

    localparam int RAM_BYTES = 4096;
    localparam int ND        = 15;

    logic        CLK = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite;
    logic [1:0]  mem_storeops;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram     [RAM_BYTES];
    logic [7:0] ref_mem [RAM_BYTES];

    mem_access_unit #(.RAM_BYTES(RAM_BYTES), .CHECK_ALIGN(1)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
        .mem_storeops(mem_storeops), .mem_read_data(mem_read_data)
    );

    always #5 CLK = ~CLK;

    // RAM environment: combinational big-endian read, byte-lane write on posedge
    function automatic logic [7:0] rb(input logic [31:0] a);
        if (a < RAM_BYTES) return ram[a[11:0]];
        return 8'h00;
    endfunction

    always_comb mem_read_data = {rb(mem_addr), rb(mem_addr + 1), rb(mem_addr + 2), rb(mem_addr + 3)};

    always @(posedge CLK) begin
        if (mem_memwrite) begin
            case (mem_storeops)
                2'd0: ram[mem_addr[11:0]] <= mem_write_data[7:0];
                2'd1: begin
                    ram[mem_addr[11:0]]      <= mem_write_data[15:8];
                    ram[mem_addr[11:0] + 1]  <= mem_write_data[7:0];
                end
                default: begin
                    ram[mem_addr[11:0]]      <= mem_write_data[31:24];
                    ram[mem_addr[11:0] + 1]  <= mem_write_data[23:16];
                    ram[mem_addr[11:0] + 2]  <= mem_write_data[15:8];
                    ram[mem_addr[11:0] + 3]  <= mem_write_data[7:0];
                end
            endcase
        end
    end

    // Reference model: rules stated as plain arithmetic on a byte array
    function automatic logic m_fault(input logic [31:0] a, input logic [1:0] sz);
        longint n;
        if (sz == 2'd3) return 1'b1;
        n = longint'(1) << sz;
        if ((longint'(a) % n) != 0) return 1'b1;
        if (longint'(a) + n > RAM_BYTES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic un);
        longint n, v;
        n = longint'(1) << sz;
        v = 0;
        for (longint i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[int'(a) + int'(i)]);
        if (!un && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        longint n;
        n = longint'(1) << sz;
        for (longint i = 0; i < n; i++)
            ref_mem[int'(a) + int'(i)] = 8'((longint'(wd) >> (8 * (n - 1 - i))) & 255);
    endtask

    // Runs one request to completion; returns what was observed, no judging here.
    task automatic exec(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int lat,
                        output int nwr, output logic mem_ok, output logic tmo);
        int k;
        tmo = 1'b0; mem_ok = 1'b1; nwr = 0; k = 0;
        while (!req_ready && k < 20) begin
            @(posedge CLK); #1; k++;
        end
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
        @(posedge CLK); #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            if (mem_memwrite) begin
                nwr++;
                if (mem_addr !== a || mem_storeops !== sz || mem_write_data !== wd) mem_ok = 1'b0;
            end
            @(posedge CLK); #1; lat++;
        end
        if (!resp_valid) tmo = 1'b1;
        rd = resp_rdata; flt = resp_fault;
        if (mem_memwrite) nwr++;
        resp_ready = 1'b1;
        @(posedge CLK); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_checks++; if (resp_rdata !== 32'd0 || resp_fault !== 1'b0) begin n_fail++; $display("FAIL reset_resp got %h/%b want 0/0", resp_rdata, resp_fault); end
        n_checks++; if (mem_addr !== 32'd0 || mem_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_write_data); end
        n_checks++; if (mem_memwrite !== 1'b0 || mem_storeops !== 2'd0) begin n_fail++; $display("FAIL reset_mem_ctl got %b/%0d want 0/0", mem_memwrite, mem_storeops); end
    endtask

    logic        d_st  [ND] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  d_sz  [ND] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    logic        d_un  [ND] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] d_a   [ND] = '{32'h10, 32'h10, 32'h10, 32'h12, 32'h21, 32'h21, 32'h21, 32'h22, 32'h22,
                                32'h13, 32'h21, 32'hFFE, 32'h0, 32'hFFC, 32'hFFFFFFFC};
    logic [31:0] d_wd  [ND] = '{32'h11223344, 32'h0, 32'h0, 32'h0, 32'hAAAAAA80, 32'h0, 32'h0, 32'h5555BEEF,
                                32'h0, 32'h0, 32'h00001234, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] d_exp [ND] = '{32'h0, 32'h11223344, 32'h00000011, 32'h00003344, 32'h0, 32'hFFFFFF80,
                                32'h00000080, 32'h0, 32'hFFFFBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        d_flt [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic test_directed();
        logic [31:0] rd, exp_rd;
        logic        flt, ok, tmo, exp_flt;
        int          lat, nwr, diff;
        for (int i = 0; i < ND; i++) begin
            exp_flt = m_fault(d_a[i], d_sz[i]);
            exp_rd  = (exp_flt || d_st[i]) ? 32'd0 : m_load(d_a[i], d_sz[i], d_un[i]);
            exec(d_st[i], d_sz[i], d_un[i], d_a[i], d_wd[i], rd, flt, lat, nwr, ok, tmo);
            if (d_st[i] && !exp_flt) m_store(d_a[i], d_sz[i], d_wd[i]);
            n_checks++; if (tmo) begin n_fail++; $display("FAIL dir%0d_timeout no resp_valid within 20 cycles", i); end
            n_checks++; if (flt !== exp_flt || flt !== d_flt[i]) begin n_fail++; $display("FAIL dir%0d_fault got %b want %b", i, flt, d_flt[i]); end
            n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL dir%0d_rdata_model got %h want %h", i, rd, exp_rd); end
            if (i != 13) begin
                n_checks++; if (rd !== d_exp[i]) begin n_fail++; $display("FAIL dir%0d_rdata got %h want %h", i, rd, d_exp[i]); end
            end
            n_checks++; if (lat != (exp_flt ? 1 : 2)) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, exp_flt ? 1 : 2); end
            n_checks++; if (nwr != ((d_st[i] && !exp_flt) ? 1 : 0) || !ok) begin n_fail++; $display("FAIL dir%0d_memwrite got %0d cycles bus_ok=%b want %0d", i, nwr, ok, (d_st[i] && !exp_flt) ? 1 : 0); end
        end
        diff = 0;
        for (int j = 0; j < RAM_BYTES; j++) if (ram[j] !== ref_mem[j]) diff++;
        n_checks++; if (diff != 0) begin n_fail++; $display("FAIL dir_ram_contents got %0d differing bytes want 0", diff); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, exp_rd;
        logic [1:0]  sz;
        logic        st, un, flt, ok, tmo, exp_flt;
        int          lat, nwr, sel, diff;
        for (int i = 0; i < 250; i++) begin
            st = 1'($urandom); un = 1'($urandom); sz = 2'($urandom); wd = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = $urandom_range(0, 63);
            else if (sel < 9)  a = RAM_BYTES - 8 + $urandom_range(0, 15);
            else               a = $urandom;
            exp_flt = m_fault(a, sz);
            exp_rd  = (exp_flt || st) ? 32'd0 : m_load(a, sz, un);
            exec(st, sz, un, a, wd, rd, flt, lat, nwr, ok, tmo);
            if (st && !exp_flt) m_store(a, sz, wd);
            n_checks++; if (tmo || flt !== exp_flt) begin n_fail++; $display("FAIL rnd%0d_fault a=%h sz=%0d got %b tmo=%b want %b", i, a, sz, flt, tmo, exp_flt); end
            n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rnd%0d_rdata a=%h sz=%0d un=%b st=%b got %h want %h", i, a, sz, un, st, rd, exp_rd); end
            n_checks++; if (lat != (exp_flt ? 1 : 2)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, exp_flt ? 1 : 2); end
            n_checks++; if (nwr != ((st && !exp_flt) ? 1 : 0) || !ok) begin n_fail++; $display("FAIL rnd%0d_memwrite got %0d bus_ok=%b want %0d", i, nwr, ok, (st && !exp_flt) ? 1 : 0); end
        end
        diff = 0;
        for (int j = 0; j < RAM_BYTES; j++) if (ram[j] !== ref_mem[j]) diff++;
        n_checks++; if (diff != 0) begin n_fail++; $display("FAIL rnd_ram_contents got %0d differing bytes want 0", diff); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_rd;
        int          k;
        exp_rd = m_load(32'h10, 2'd2, 1'b0);
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        k = 0;
        while (!resp_valid && k < 20) begin @(posedge CLK); #1; k++; end
        for (int c = 0; c < 4; c++) begin
            req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_addr = 32'h30; req_wdata = 32'h5A;
            n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_rd) begin n_fail++; $display("FAIL bp%0d_hold got %b/%h want 1/%h", c, resp_valid, resp_rdata, exp_rd); end
            n_checks++; if (req_ready !== 1'b0 || mem_memwrite !== 1'b0) begin n_fail++; $display("FAIL bp%0d_ignore req_ready=%b memwrite=%b want 0/0", c, req_ready, mem_memwrite); end
            @(posedge CLK); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge CLK); #1;
        resp_ready = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid); end
        n_checks++; if (ram[8'h30] !== ref_mem[8'h30]) begin n_fail++; $display("FAIL bp_ram got %h want %h", ram[8'h30], ref_mem[8'h30]); end
    endtask

    task automatic test_back_to_back();
        int acc, rsp;
        logic [31:0] exp_rd;
        exp_rd = m_load(32'h10, 2'd2, 1'b0);
        acc = 0; rsp = 0;
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        resp_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (req_ready) acc++;
            if (resp_valid) begin
                rsp++;
                n_checks++; if (resp_rdata !== exp_rd) begin n_fail++; $display("FAIL b2b_rdata got %h want %h", resp_rdata, exp_rd); end
            end
            @(posedge CLK); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        n_checks++; if (acc != 10 || rsp != 10) begin n_fail++; $display("FAIL b2b_throughput got %0d accepts %0d responses want 10/10", acc, rsp); end
    endtask

    task automatic test_reset_midflight();
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        n_checks++; if (mem_addr !== 32'h10 || mem_storeops !== 2'd2) begin n_fail++; $display("FAIL rstmid_latched got %h/%0d want 00000010/2", mem_addr, mem_storeops); end
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_state got req_ready=%b resp_valid=%b want 1/0", req_ready, resp_valid); end
        n_checks++; if (mem_addr !== 32'd0 || mem_write_data !== 32'd0 || mem_storeops !== 2'd0 || mem_memwrite !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_mem got %h/%h/%0d/%b want all 0", mem_addr, mem_write_data, mem_storeops, mem_memwrite);
        end
        n_checks++; if (resp_rdata !== 32'd0 || resp_fault !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp got %h/%b want 0/0", resp_rdata, resp_fault); end
        repeat (3) @(posedge CLK); #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped got resp_valid=%b want 0", resp_valid); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < RAM_BYTES; i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
